ibex_ex_issue_seq: RTL and testbench

- ID-side issue sequencer facing the execute block. It drives the enables and first-cycle strobes that EX consumes, and it owns the 2x34-bit intermediate-value register that EX reads and writes.
- It tracks each instruction from issue to writeback acceptance using ex_valid and the writeback-ready handshake.
- It handles flush mid-operation and flags runaway multicycle operations with a watchdog.

---
 rtl/ibex_ex_issue_seq.sv | 126 ++++++++++++
 tb/tb_ibex_ex_issue_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ibex_ex_issue_seq.sv
// ID-side issue sequencer for the execute block: first-cycle strobes, dynamic mult/div enables,
// writeback handshake tracking, flush handling, a multicycle watchdog and the intermediate regs.
module ibex_ex_issue_seq #(
    parameter bit          RV32MEn   = 1'b1,
    parameter int unsigned MaxCycles = 40
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             instr_valid_i,
    input  logic             instr_is_mult_i,
    input  logic             instr_is_div_i,
    input  logic             flush_i,
    input  logic             wb_ready_i,
    input  logic             ex_valid_i,
    input  logic [1:0]       imd_val_we_i,
    input  logic [1:0][33:0] imd_val_d_i,
    output logic [1:0][33:0] imd_val_q_o,
    output logic             mult_en_o,
    output logic             div_en_o,
    output logic             alu_instr_first_cycle_o,
    output logic             multdiv_ready_id_o,
    output logic             instr_done_o,
    output logic             stall_o,
    output logic             timeout_err_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StWaitWb
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       cnt_inc;
    logic [1:0][33:0] imd_val_q;
    logic             done, timeout, first_cycle, md_allowed;

    assign cnt_inc = (cnt_q == 8'hff) ? cnt_q : cnt_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done        = 1'b0;
        timeout     = 1'b0;
        first_cycle = 1'b0;
        if (flush_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (instr_valid_i) begin
                        first_cycle = 1'b1;
                        if (ex_valid_i && wb_ready_i) begin
                            done = 1'b1;
                        end else if (ex_valid_i) begin
                            state_d = StWaitWb;
                        end else begin
                            state_d = StExec;
                            cnt_d   = 8'd1;
                        end
                    end
                end
                StExec: begin
                    if (!ex_valid_i && (cnt_q == 8'(MaxCycles))) begin
                        timeout = 1'b1;
                        state_d = StIdle;
                    end else if (!instr_valid_i) begin
                        // Protocol violation: drop the instruction without retiring it.
                        state_d = StIdle;
                    end else if (ex_valid_i && wb_ready_i) begin
                        done    = 1'b1;
                        state_d = StIdle;
                    end else if (ex_valid_i) begin
                        state_d = StWaitWb;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StWaitWb: begin
                    if (!instr_valid_i) begin
                        state_d = StIdle;
                    end else if (wb_ready_i) begin
                        done    = 1'b1;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        if (state_d != StExec) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            imd_val_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < 2; i++) begin
                if (imd_val_we_i[i] && !flush_i) begin
                    imd_val_q[i] <= imd_val_d_i[i];
                end
            end
        end
    end

    // All handshake outputs are held low while reset is applied.
    assign md_allowed = RV32MEn && !rst_i && instr_valid_i && !flush_i && (state_q != StWaitWb);

    assign imd_val_q_o             = imd_val_q;
    assign mult_en_o               = md_allowed && instr_is_mult_i;
    assign div_en_o                = md_allowed && instr_is_div_i;
    assign alu_instr_first_cycle_o = !rst_i && first_cycle;
    assign multdiv_ready_id_o      = !rst_i && wb_ready_i;
    assign instr_done_o            = !rst_i && done;
    assign stall_o                 = !rst_i && instr_valid_i && !done && !flush_i;
    assign timeout_err_o           = !rst_i && timeout;
    assign busy_o                  = !rst_i && (state_q != StIdle);

endmodule

// File: tb/tb_ibex_ex_issue_seq.sv
// Bench for ibex_ex_issue_seq: directed scenarios with literal expectations plus randomized
// traffic, all compared every cycle against an instruction-lifetime model (age + result-held).
module tb_ibex_ex_issue_seq;
    localparam int unsigned MAXC = 4;

    logic             clk = 1'b0;
    logic             rst, valid, is_mult, is_div, flush, wb_ready, ex_valid;
    logic [1:0]       we;
    logic [1:0][33:0] imd_d;
    logic [1:0][33:0] imd_q;
    logic mult_en, div_en, first, md_rdy, done, stall, tmo, busy;

    ibex_ex_issue_seq #(.RV32MEn(1'b1), .MaxCycles(MAXC)) dut (
        .clk_i(clk), .rst_i(rst), .instr_valid_i(valid), .instr_is_mult_i(is_mult),
        .instr_is_div_i(is_div), .flush_i(flush), .wb_ready_i(wb_ready), .ex_valid_i(ex_valid),
        .imd_val_we_i(we), .imd_val_d_i(imd_d), .imd_val_q_o(imd_q), .mult_en_o(mult_en),
        .div_en_o(div_en), .alu_instr_first_cycle_o(first), .multdiv_ready_id_o(md_rdy),
        .instr_done_o(done), .stall_o(stall), .timeout_err_o(tmo), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 0;

    // Model: is an instruction in flight, how many cycles since issue, has EX delivered its result.
    bit               m_fl, m_held, n_fl, n_held;
    int               m_age, n_age;
    logic [1:0][33:0] m_imd, n_imd;
    bit               e_done, e_to;

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drv(input logic v, input logic m, input logic dv, input logic fl,
                       input logic wr, input logic ex, input logic [1:0] w);
        valid = v; is_mult = m; is_div = dv; flush = fl; wb_ready = wr; ex_valid = ex; we = w;
    endtask

    // Evaluate the cycle at the falling edge and prepare the model's next state.
    task automatic cyc_a();
        bit e_first, e_stall, e_men, e_den, e_busy, e_rdy;
        @(negedge clk);
        e_to    = !rst && m_fl && !m_held && (m_age == MAXC) && !ex_valid && !flush;
        e_done  = !rst && valid && !flush && wb_ready && (m_fl ? (m_held || ex_valid) : ex_valid);
        e_first = !rst && valid && !flush && !m_fl;
        e_stall = !rst && valid && !e_done && !flush;
        e_men   = !rst && valid && is_mult && !flush && !(m_fl && m_held);
        e_den   = !rst && valid && is_div && !flush && !(m_fl && m_held);
        e_busy  = !rst && m_fl;
        e_rdy   = !rst && wb_ready;
        if (chk_en) begin
            chk("imd_q", imd_q, m_imd);
            chk("mult_en", mult_en, e_men);
            chk("div_en", div_en, e_den);
            chk("first", first, e_first);
            chk("md_rdy", md_rdy, e_rdy);
            chk("done", done, e_done);
            chk("stall", stall, e_stall);
            chk("timeout", tmo, e_to);
            chk("busy", busy, e_busy);
        end
        n_fl = m_fl; n_held = m_held; n_age = m_age; n_imd = m_imd;
        if (rst) begin
            n_fl = 0; n_held = 0; n_age = 0; n_imd = '0;
        end else begin
            for (int i = 0; i < 2; i++) if (we[i] && !flush) n_imd[i] = imd_d[i];
            if (flush || e_done || e_to || (m_fl && !valid)) begin
                n_fl = 0; n_held = 0; n_age = 0;
            end else if (!m_fl && valid) begin
                n_fl = 1; n_held = ex_valid; n_age = 1;
            end else if (m_fl && !m_held) begin
                if (ex_valid) n_held = 1;
                else n_age = (m_age >= 255) ? 255 : m_age + 1;
            end
        end
    endtask

    task automatic cyc_b();
        @(posedge clk);
        m_fl = n_fl; m_held = n_held; m_age = n_age; m_imd = n_imd;
        chk_en = 1;
        #1;
    endtask

    task automatic cyc();
        cyc_a();
        cyc_b();
    endtask

    bit pend, p_m, p_d;
    int kind;

    initial begin
        rst = 1; imd_d = '0;
        drv(0, 0, 0, 0, 0, 0, 2'b00);
        m_fl = 0; m_held = 0; m_age = 0; m_imd = '0;
        cyc(); cyc();
        rst = 0;
        cyc();

        // ADD: completes in its issue cycle
        drv(1, 0, 0, 0, 1, 1, 2'b00);
        cyc_a();
        chk("add_first", first, 1'b1); chk("add_done", done, 1'b1);
        chk("add_busy", busy, 1'b0); chk("add_stall", stall, 1'b0);
        cyc_b();
        drv(0, 0, 0, 0, 1, 0, 2'b00); cyc();

        // MUL, 3 cycles, writes imd[0] in cycle 1
        drv(1, 1, 0, 0, 1, 0, 2'b01); imd_d[0] = 34'h2_0000_0005;
        cyc_a(); chk("mul1_en", mult_en, 1'b1); chk("mul1_first", first, 1'b1); cyc_b();
        drv(1, 1, 0, 0, 1, 0, 2'b00); imd_d = '0;
        cyc_a(); chk("mul2_en", mult_en, 1'b1); chk("mul2_imd", imd_q[0], 34'h2_0000_0005);
        chk("mul2_first", first, 1'b0); cyc_b();
        drv(1, 1, 0, 0, 1, 1, 2'b00);
        cyc_a(); chk("mul3_en", mult_en, 1'b1); chk("mul3_done", done, 1'b1); cyc_b();
        drv(0, 0, 0, 0, 1, 0, 2'b00);
        cyc_a(); chk("mul4_busy", busy, 1'b0); cyc_b();

        // Writeback backpressure
        drv(1, 1, 0, 0, 0, 0, 2'b00); cyc();
        drv(1, 1, 0, 0, 0, 1, 2'b00); cyc();
        drv(1, 1, 0, 0, 0, 0, 2'b00);
        for (int c = 3; c <= 4; c++) begin
            cyc_a(); chk("bp_men", mult_en, 1'b0); chk("bp_stall", stall, 1'b1);
            chk("bp_done", done, 1'b0); chk("bp_busy", busy, 1'b1); cyc_b();
        end
        drv(1, 1, 0, 0, 1, 0, 2'b00);
        cyc_a(); chk("bp5_done", done, 1'b1); chk("bp5_stall", stall, 1'b0); cyc_b();
        drv(0, 0, 0, 0, 1, 0, 2'b00); cyc();

        // DIV flushed in cycle 4 together with ex_valid and a double imd write
        drv(1, 0, 1, 0, 1, 0, 2'b00);
        cyc(); cyc(); cyc();
        drv(1, 0, 1, 1, 1, 1, 2'b11); imd_d[0] = 34'h1; imd_d[1] = 34'h2;
        cyc_a(); chk("fl_done", done, 1'b0); chk("fl_den", div_en, 1'b0); cyc_b();
        drv(1, 0, 1, 0, 1, 1, 2'b00); imd_d = '0;
        cyc_a(); chk("fl5_first", first, 1'b1); chk("fl5_busy", busy, 1'b0);
        chk("fl5_imd0", imd_q[0], 34'h2_0000_0005); chk("fl5_imd1", imd_q[1], 34'h0); cyc_b();
        drv(0, 0, 0, 0, 1, 0, 2'b00); cyc();

        // Watchdog: DIV that never delivers, then reissue and time out again
        drv(1, 0, 1, 0, 1, 0, 2'b00);
        for (int c = 1; c <= 10; c++) begin
            cyc_a();
            chk("wd_tmo", tmo, (c == 5 || c == 10) ? 1'b1 : 1'b0);
            if (c == 6) begin
                chk("wd6_busy", busy, 1'b0); chk("wd6_first", first, 1'b1);
            end
            cyc_b();
        end
        drv(0, 0, 0, 0, 1, 0, 2'b00); cyc();

        // Reset while in EXEC with imd = {7,5}
        drv(1, 1, 0, 0, 1, 0, 2'b11); imd_d[0] = 34'd5; imd_d[1] = 34'd7;
        cyc();
        drv(1, 1, 0, 0, 1, 0, 2'b00); imd_d = '0;
        cyc_a(); chk("rs_imd", imd_q, {34'd7, 34'd5}); chk("rs_busy0", busy, 1'b1); cyc_b();
        rst = 1;
        cyc();
        cyc_a(); chk("rs_imd0", imd_q, 68'h0); chk("rs_busy", busy, 1'b0);
        chk("rs_first", first, 1'b0); chk("rs_stall", stall, 1'b0);
        chk("rs_men", mult_en, 1'b0); chk("rs_rdy", md_rdy, 1'b0); cyc_b();
        rst = 0;
        cyc_a(); chk("rs_reissue", first, 1'b1); cyc_b();
        drv(0, 0, 0, 0, 1, 0, 2'b00); cyc();

        // Randomized traffic obeying the hold-until-done protocol
        pend = 0;
        for (int n = 0; n < 4000; n++) begin
            if (!pend && ($urandom_range(0, 1) == 1)) begin
                pend = 1;
                kind = $urandom_range(0, 2);
                p_m = (kind == 1); p_d = (kind == 2);
            end
            rst = ($urandom_range(0, 63) == 0);
            drv(pend, pend && p_m, pend && p_d, $urandom_range(0, 15) == 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)));
            for (int i = 0; i < 2; i++) imd_d[i] = {2'($urandom_range(0, 3)), 32'($urandom)};
            cyc_a();
            if (rst || flush || e_done || e_to) pend = 0;
            cyc_b();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
